// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with load-use stall detection and MEM/WB operand forwarding.
// Drives the ALU operands, the store data and the registered control for the execute stage.

module id_ex_operand_fwd #(
   parameter int XLEN = 32
) (
   input  logic [4:0]      rsE,
   input  logic [4:0]      rdM,
   input  logic [4:0]      rdW,
   input  logic            regWriteM,
   input  logic            regWriteW,
   input  logic [XLEN-1:0] regVal,
   input  logic [XLEN-1:0] aluResultM,
   input  logic [XLEN-1:0] resultW,
   output logic [1:0]      fwdSel,
   output logic [XLEN-1:0] fwdVal
);
   // MEM is the younger producer, so it wins over WB; x0 is hardwired and never forwarded
   always_comb begin
      fwdSel = 2'b00;
      if (regWriteM && (rdM != 5'd0) && (rdM == rsE))
         fwdSel = 2'b10;
      else if (regWriteW && (rdW != 5'd0) && (rdW == rsE))
         fwdSel = 2'b01;
   end

   always_comb begin
      case (fwdSel)
         2'b00:   fwdVal = regVal;
         2'b01:   fwdVal = resultW;
         default: fwdVal = aluResultM;
      endcase
   end
endmodule

module id_ex_forward_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] RD1_D,
   input  logic [XLEN-1:0] RD2_D,
   input  logic [XLEN-1:0] Imm_Ext_D,
   input  logic [XLEN-1:0] PC_D,
   input  logic [XLEN-1:0] PCPlus4_D,
   input  logic [4:0]      RS1_D,
   input  logic [4:0]      RS2_D,
   input  logic [4:0]      RD_D,
   input  logic [2:0]      ALUControl_D,
   input  logic            ALUSrc_D,
   input  logic            RegWrite_D,
   input  logic            MemWrite_D,
   input  logic            ResultSrc_D,
   input  logic            Branch_D,
   input  logic            Flush_E,
   input  logic [4:0]      RD_M,
   input  logic [4:0]      RD_W,
   input  logic            RegWrite_M,
   input  logic            RegWrite_W,
   input  logic [XLEN-1:0] ALUResult_M,
   input  logic [XLEN-1:0] Result_W,
   output logic [XLEN-1:0] SrcA_E,
   output logic [XLEN-1:0] SrcB_E,
   output logic [2:0]      ALUControl_E,
   output logic [XLEN-1:0] WriteData_E,
   output logic [XLEN-1:0] PC_E,
   output logic [XLEN-1:0] PCPlus4_E,
   output logic [XLEN-1:0] Imm_Ext_E,
   output logic [4:0]      RD_E,
   output logic [4:0]      RS1_E,
   output logic [4:0]      RS2_E,
   output logic            RegWrite_E,
   output logic            MemWrite_E,
   output logic            ResultSrc_E,
   output logic            Branch_E,
   output logic [1:0]      ForwardA_E,
   output logic [1:0]      ForwardB_E,
   output logic            Stall_FD
);
   localparam int NUM_OPS = 2;

   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcPlus4;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      aluCtl;
      logic            aluSrc;
      logic            regWrite;
      logic            memWrite;
      logic            resultSrc;
      logic            branch;
   } idExT;

   idExT exReg;
   idExT exNext;

   // a load in E whose destination feeds the decode instruction must wait one cycle
   assign Stall_FD = exReg.resultSrc && (exReg.rd != 5'd0) &&
                     ((exReg.rd == RS1_D) || (exReg.rd == RS2_D));

   // bubble is the all-zero entry; flush and stall coincide into a single bubble
   always_comb begin
      exNext = '{rd1: RD1_D, rd2: RD2_D, imm: Imm_Ext_D, pc: PC_D, pcPlus4: PCPlus4_D,
                 rs1: RS1_D, rs2: RS2_D, rd: RD_D, aluCtl: ALUControl_D,
                 aluSrc: ALUSrc_D, regWrite: RegWrite_D, memWrite: MemWrite_D,
                 resultSrc: ResultSrc_D, branch: Branch_D};
      if (Flush_E || Stall_FD)
         exNext = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) exReg <= '0;
      else      exReg <= exNext;
   end

   logic [NUM_OPS-1:0][4:0]      rsE;
   logic [NUM_OPS-1:0][XLEN-1:0] regVal;
   logic [NUM_OPS-1:0][1:0]      fwdSel;
   logic [NUM_OPS-1:0][XLEN-1:0] fwdVal;

   assign rsE[0]    = exReg.rs1;
   assign rsE[1]    = exReg.rs2;
   assign regVal[0] = exReg.rd1;
   assign regVal[1] = exReg.rd2;

   for (genvar i = 0; i < NUM_OPS; i++) begin : gOp
      id_ex_operand_fwd #(.XLEN(XLEN)) uFwd (
         .rsE       (rsE[i]),
         .rdM       (RD_M),
         .rdW       (RD_W),
         .regWriteM (RegWrite_M),
         .regWriteW (RegWrite_W),
         .regVal    (regVal[i]),
         .aluResultM(ALUResult_M),
         .resultW   (Result_W),
         .fwdSel    (fwdSel[i]),
         .fwdVal    (fwdVal[i])
      );
   end

   assign ForwardA_E   = fwdSel[0];
   assign ForwardB_E   = fwdSel[1];
   assign SrcA_E       = fwdVal[0];
   assign SrcB_E       = exReg.aluSrc ? exReg.imm : fwdVal[1];
   assign WriteData_E  = fwdVal[1];
   assign ALUControl_E = exReg.aluCtl;
   assign PC_E         = exReg.pc;
   assign PCPlus4_E    = exReg.pcPlus4;
   assign Imm_Ext_E    = exReg.imm;
   assign RD_E         = exReg.rd;
   assign RS1_E        = exReg.rs1;
   assign RS2_E        = exReg.rs2;
   assign RegWrite_E   = exReg.regWrite;
   assign MemWrite_E   = exReg.memWrite;
   assign ResultSrc_E  = exReg.resultSrc;
   assign Branch_E     = exReg.branch;
endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Bench for id_ex_forward_stage: directed hazard/forwarding steps, then random traffic
// compared against a behavioural model of the execute-stage entry.

module tb_id_ex_forward_stage;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] RD1_D, RD2_D, Imm_Ext_D, PC_D, PCPlus4_D;
   logic [4:0]      RS1_D, RS2_D, RD_D;
   logic [2:0]      ALUControl_D;
   logic            ALUSrc_D, RegWrite_D, MemWrite_D, ResultSrc_D, Branch_D;
   logic            Flush_E;
   logic [4:0]      RD_M, RD_W;
   logic            RegWrite_M, RegWrite_W;
   logic [XLEN-1:0] ALUResult_M, Result_W;
   logic [XLEN-1:0] SrcA_E, SrcB_E, WriteData_E, PC_E, PCPlus4_E, Imm_Ext_E;
   logic [2:0]      ALUControl_E;
   logic [4:0]      RD_E, RS1_E, RS2_E;
   logic            RegWrite_E, MemWrite_E, ResultSrc_E, Branch_E, Stall_FD;
   logic [1:0]      ForwardA_E, ForwardB_E;

   always #5 clk = ~clk;

   id_ex_forward_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_Ext_D(Imm_Ext_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
      .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D), .ALUControl_D(ALUControl_D),
      .ALUSrc_D(ALUSrc_D), .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D),
      .ResultSrc_D(ResultSrc_D), .Branch_D(Branch_D), .Flush_E(Flush_E),
      .RD_M(RD_M), .RD_W(RD_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .ALUResult_M(ALUResult_M), .Result_W(Result_W),
      .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .ALUControl_E(ALUControl_E), .WriteData_E(WriteData_E),
      .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .Imm_Ext_E(Imm_Ext_E),
      .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E),
      .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ResultSrc_E(ResultSrc_E),
      .Branch_E(Branch_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Stall_FD(Stall_FD)
   );

   // model of the instruction currently sitting in execute
   typedef struct {
      logic [31:0] rd1, rd2, imm, pc, pcp4;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  alu;
      logic        aluSrc, rw, mw, ld, br;
   } exT;

   exT m;
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic modelStall();
      return m.ld && (m.rd != 0) && (m.rd == RS1_D || m.rd == RS2_D);
   endfunction

   // youngest writer of a nonzero register wins; otherwise the register-file value stands
   function automatic logic [1:0] modelSel(input logic [4:0] rs);
      if (rs == 0) return 2'd0;
      if (RegWrite_M && RD_M == rs) return 2'd2;
      if (RegWrite_W && RD_W == rs) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [31:0] modelVal(input logic [4:0] rs, input logic [31:0] rf);
      logic [1:0] s;
      s = modelSel(rs);
      return (s == 2) ? ALUResult_M : (s == 1) ? Result_W : rf;
   endfunction

   task automatic checkAll(input string tag);
      logic [31:0] opB;
      opB = modelVal(m.rs2, m.rd2);
      chk({tag, ".SrcA"},     SrcA_E,      modelVal(m.rs1, m.rd1));
      chk({tag, ".SrcB"},     SrcB_E,      m.aluSrc ? m.imm : opB);
      chk({tag, ".WData"},    WriteData_E, opB);
      chk({tag, ".ALUCtl"},   ALUControl_E, m.alu);
      chk({tag, ".PC"},       PC_E,        m.pc);
      chk({tag, ".PC4"},      PCPlus4_E,   m.pcp4);
      chk({tag, ".Imm"},      Imm_Ext_E,   m.imm);
      chk({tag, ".RD"},       RD_E,        m.rd);
      chk({tag, ".RS1"},      RS1_E,       m.rs1);
      chk({tag, ".RS2"},      RS2_E,       m.rs2);
      chk({tag, ".RegWr"},    RegWrite_E,  m.rw);
      chk({tag, ".MemWr"},    MemWrite_E,  m.mw);
      chk({tag, ".ResSrc"},   ResultSrc_E, m.ld);
      chk({tag, ".Branch"},   Branch_E,    m.br);
      chk({tag, ".FwdA"},     ForwardA_E,  modelSel(m.rs1));
      chk({tag, ".FwdB"},     ForwardB_E,  modelSel(m.rs2));
      chk({tag, ".Stall"},    Stall_FD,    modelStall());
   endtask

   task automatic zeroModel();
      m = '{rd1: 0, rd2: 0, imm: 0, pc: 0, pcp4: 0, rs1: 0, rs2: 0, rd: 0, alu: 0,
            aluSrc: 0, rw: 0, mw: 0, ld: 0, br: 0};
   endtask

   // one rising edge; the model decides capture vs bubble from pre-edge inputs
   task automatic tick();
      logic bub;
      bub = Flush_E || modelStall();
      @(posedge clk);
      if (!rst || bub) zeroModel();
      else m = '{rd1: RD1_D, rd2: RD2_D, imm: Imm_Ext_D, pc: PC_D, pcp4: PCPlus4_D,
                 rs1: RS1_D, rs2: RS2_D, rd: RD_D, alu: ALUControl_D, aluSrc: ALUSrc_D,
                 rw: RegWrite_D, mw: MemWrite_D, ld: ResultSrc_D, br: Branch_D};
      #1;
   endtask

   task automatic setD(input logic [31:0] rd1, rd2, imm, pc, input logic [4:0] rs1, rs2, rd,
                       input logic [2:0] alu, input logic aluSrc, rw, mw, ld, br);
      RD1_D = rd1; RD2_D = rd2; Imm_Ext_D = imm; PC_D = pc; PCPlus4_D = pc + 32'd4;
      RS1_D = rs1; RS2_D = rs2; RD_D = rd; ALUControl_D = alu;
      ALUSrc_D = aluSrc; RegWrite_D = rw; MemWrite_D = mw; ResultSrc_D = ld; Branch_D = br;
   endtask

   task automatic clearFwd();
      RD_M = 0; RD_W = 0; RegWrite_M = 0; RegWrite_W = 0; ALUResult_M = 0; Result_W = 0;
   endtask

   initial begin
      zeroModel();
      clearFwd();
      Flush_E = 0;
      rst = 1'b0;
      setD(32'hAAAA, 32'hBBBB, 32'hCC, 32'h100, 5'd1, 5'd2, 5'd3, 3'b011, 1, 1, 1, 1, 1);
      #22;
      checkAll("reset");
      chk("reset.Stall0", Stall_FD, 0);
      chk("reset.RD0", RD_E, 0);

      @(negedge clk);
      rst = 1'b1;
      setD(32'hAAAA, 32'hBBBB, 32'hCC, 32'h100, 5'd1, 5'd2, 5'd3, 3'b011, 1, 1, 1, 0, 1);
      tick();
      checkAll("release");
      chk("release.PC", PC_E, 32'h100);
      chk("release.RD", RD_E, 5'd3);

      // add x3,x1,x2 with RD1=5, MEM producing x1
      setD(32'd5, 32'd7, 32'd0, 32'h200, 5'd1, 5'd2, 5'd3, 3'b000, 0, 1, 0, 0, 0);
      tick();
      RD_M = 5'd1; RegWrite_M = 1; ALUResult_M = 32'h1234;
      #1;
      checkAll("memfwd");
      chk("memfwd.FwdA", ForwardA_E, 2'b10);
      chk("memfwd.SrcA", SrcA_E, 32'h1234);
      RD_W = 5'd1; RegWrite_W = 1; Result_W = 32'hBEEF;
      #1;
      chk("memprio.SrcA", SrcA_E, 32'h1234);
      RD_M = 5'd0;
      #1;
      checkAll("wbfwd");
      chk("wbfwd.SrcA", SrcA_E, 32'hBEEF);
      chk("wbfwd.FwdA", ForwardA_E, 2'b01);

      // x0 source with immediate operand
      setD(32'd9, 32'h55, 32'h10, 32'h204, 5'd4, 5'd0, 5'd6, 3'b000, 1, 1, 0, 0, 0);
      tick();
      RD_M = 5'd0; RegWrite_M = 1;
      #1;
      checkAll("x0");
      chk("x0.FwdB", ForwardB_E, 2'b00);
      chk("x0.SrcB", SrcB_E, 32'h10);
      chk("x0.WData", WriteData_E, 32'h55);
      clearFwd();

      // lw x5 followed by add x7,x5,x6
      setD(32'd1, 32'd0, 32'd8, 32'h208, 5'd1, 5'd0, 5'd5, 3'b000, 1, 1, 0, 1, 0);
      tick();
      setD(32'h77, 32'h66, 32'd0, 32'h20C, 5'd5, 5'd6, 5'd7, 3'b000, 0, 1, 0, 0, 0);
      #1;
      chk("lu.Stall", Stall_FD, 1);
      tick();
      checkAll("lu.bubble");
      chk("lu.bubRegWr", RegWrite_E, 0);
      chk("lu.bubStall", Stall_FD, 0);
      tick();
      checkAll("lu.enter");
      chk("lu.enterRD", RD_E, 5'd7);
      chk("lu.enterRS1", RS1_E, 5'd5);

      // flush a store in decode
      setD(32'h11, 32'h22, 32'h4, 32'h210, 5'd2, 5'd3, 5'd0, 3'b000, 1, 0, 1, 0, 0);
      Flush_E = 1;
      tick();
      Flush_E = 0;
      checkAll("flush");
      chk("flush.MemWr", MemWrite_E, 0);
      chk("flush.PC", PC_E, 0);

      // flush coinciding with a load-use stall yields one bubble
      setD(32'd2, 32'd0, 32'd0, 32'h214, 5'd1, 5'd0, 5'd9, 3'b000, 1, 1, 0, 1, 0);
      tick();
      setD(32'h99, 32'h88, 32'd0, 32'h218, 5'd9, 5'd2, 5'd10, 3'b111, 0, 1, 0, 0, 1);
      Flush_E = 1;
      tick();
      Flush_E = 0;
      checkAll("flstall.bubble");
      tick();
      checkAll("flstall.enter");
      chk("flstall.PC", PC_E, 32'h218);

      for (int i = 0; i < 400; i++) begin
         setD($urandom, $urandom, $urandom, $urandom,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 2) == 0), 1'($urandom));
         RD_M = 5'($urandom_range(0, 3)); RD_W = 5'($urandom_range(0, 3));
         RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom);
         ALUResult_M = $urandom; Result_W = $urandom;
         Flush_E = ($urandom_range(0, 7) == 0);
         if (i == 200) begin
            rst = 1'b0;
            zeroModel();
            #1;
            checkAll("rnd.rst");
            tick();
            @(negedge clk);
            rst = 1'b1;
         end
         #1;
         checkAll("rnd.pre");
         tick();
         checkAll("rnd.post");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
